// File: rtl/phys_bus_arbiter_pkg.sv
// rtl/phys_bus_arbiter_pkg.sv - shared types for the physical bus arbiter
package phys_bus_arbiter_pkg;

  // Bus request payload widths; the arbiter's ADDR_WIDTH/DATA_WIDTH must match these.
  localparam int BUS_ADDR_WIDTH = 32;
  localparam int BUS_DATA_WIDTH = 32;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } arb_owner_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [BUS_ADDR_WIDTH-1:0]   addr;
    logic [BUS_DATA_WIDTH-1:0]   wdata;
    logic                        read_write;
    logic [BUS_DATA_WIDTH/8-1:0] column_strobe;
  } bus_req_t;

  // Fetches are always full-word reads.
  function automatic bus_req_t make_fetch_req(input logic [BUS_ADDR_WIDTH-1:0] addr);
    bus_req_t r;
    r.addr          = addr;
    r.wdata         = '0;
    r.read_write    = 1'b0;
    r.column_strobe = '1;
    return r;
  endfunction

endpackage

// File: rtl/phys_bus_arbiter_timeout.sv
// rtl/phys_bus_arbiter_timeout.sv - bus_timeout_counter: flags the last allowed cycle of a transaction
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  assign expired = enable && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/phys_bus_arbiter.sv
// rtl/phys_bus_arbiter.sv - IF/MEM arbiter for the physical bus with timeout faults
// Optional MEM-streak fairness toward IF is enabled by defining ARB_FAIRNESS_EN.
module phys_bus_arbiter
  import phys_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH     = BUS_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int MAX_MEM_GRANTS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_stall,
  output logic                    if_bus_fault,
  input  logic                    mem_req,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_read_write,
  input  logic [DATA_WIDTH/8-1:0] mem_column_strobe,
  output logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    mem_stall,
  output logic                    mem_bus_fault,
  output logic                    phys_req,
  output logic [ADDR_WIDTH-1:0]   phys_addr,
  output logic [DATA_WIDTH-1:0]   phys_wdata,
  output logic                    phys_read_write,
  output logic [DATA_WIDTH/8-1:0] phys_column_strobe,
  input  logic [DATA_WIDTH-1:0]   phys_rdata,
  input  logic                    phys_ack
);

  arb_state_t state, state_next;
  arb_owner_t owner, owner_next, grant_owner;
  bus_req_t   bus_q, bus_next, mem_bus;
  logic       phys_req_next;
  logic       owner_req;
  logic       fair_force_if;
  logic       timeout_clear, timeout_enable, timeout_expired;
  logic       if_done, mem_done, if_fault, mem_fault;

  bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (timeout_clear),
    .enable  (timeout_enable),
    .expired (timeout_expired)
  );

`ifdef ARB_FAIRNESS_EN
  localparam int GCW = $clog2(MAX_MEM_GRANTS + 1);
  localparam logic [GCW-1:0] GRANT_LIMIT = GCW'(MAX_MEM_GRANTS);

  logic [GCW-1:0] grant_cnt;

  assign fair_force_if = if_req && mem_req && (grant_cnt == GRANT_LIMIT);

  // Counts MEM grants that made a pending fetch wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt <= '0;
    end else if (state == ARB_IDLE) begin
      if (!if_req || grant_owner == OWNER_IF) begin
        grant_cnt <= '0;
      end else begin
        grant_cnt <= grant_cnt + 1'b1;
      end
    end
  end
`else
  assign fair_force_if = 1'b0;
  if (MAX_MEM_GRANTS > 0) begin : g_strict_mem_priority
  end
`endif

  assign grant_owner = (mem_req && !fair_force_if) ? OWNER_MEM : OWNER_IF;
  assign owner_req   = (owner == OWNER_IF) ? if_req : mem_req;

  always_comb begin
    mem_bus.addr          = mem_addr;
    mem_bus.wdata         = mem_wdata;
    mem_bus.read_write    = mem_read_write;
    mem_bus.column_strobe = mem_column_strobe;
  end

  always_comb begin
    state_next     = state;
    owner_next     = owner;
    bus_next       = bus_q;
    phys_req_next  = phys_req;
    timeout_clear  = 1'b1;
    timeout_enable = 1'b0;
    if_done        = 1'b0;
    mem_done       = 1'b0;
    if_fault       = 1'b0;
    mem_fault      = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (if_req || mem_req) begin
          owner_next    = grant_owner;
          bus_next      = (grant_owner == OWNER_MEM) ? mem_bus : make_fetch_req(if_addr);
          phys_req_next = 1'b1;
          state_next    = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        timeout_clear  = 1'b0;
        timeout_enable = 1'b1;
        if (phys_ack || timeout_expired) begin
          state_next    = ARB_IDLE;
          phys_req_next = 1'b0;
          // An ack in the final timeout cycle still counts as a clean completion.
          if (owner_req) begin
            if (owner == OWNER_IF) begin
              if_done  = 1'b1;
              if_fault = !phys_ack;
            end else begin
              mem_done  = 1'b1;
              mem_fault = !phys_ack;
            end
          end
        end else if (!owner_req) begin
          state_next = ARB_DRAIN;
        end
      end
      ARB_DRAIN: begin
        timeout_clear  = 1'b0;
        timeout_enable = 1'b1;
        if (phys_ack || timeout_expired) begin
          state_next    = ARB_IDLE;
          phys_req_next = 1'b0;
        end
      end
      default: begin
        state_next    = ARB_IDLE;
        phys_req_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      owner    <= OWNER_MEM;
      bus_q    <= '0;
      phys_req <= 1'b0;
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      bus_q    <= bus_next;
      phys_req <= phys_req_next;
    end
  end

  assign phys_addr          = bus_q.addr;
  assign phys_wdata         = bus_q.wdata;
  assign phys_read_write    = bus_q.read_write;
  assign phys_column_strobe = bus_q.column_strobe;

  assign if_stall      = if_req && !if_done;
  assign mem_stall     = mem_req && !mem_done;
  assign if_bus_fault  = if_fault;
  assign mem_bus_fault = mem_fault;
  assign if_rdata      = (if_done && !if_fault) ? phys_rdata : '0;
  assign mem_rdata     = (mem_done && !mem_fault) ? phys_rdata : '0;

endmodule

// File: doc/phys_bus_arbiter.md
Name: phys_bus_arbiter

Overview:
- Shares the single physical memory bus between the instruction-fetch port and the memory-access port of the core.
- Sits between the MMU's translated fetch/data requests and the external physical bus.
- Sequences one transaction at a time and generates per-port stall and bus-fault signals consumed by the pipeline hazard logic.
- Enforces a bus timeout so a hung slave becomes a bus fault (exception) rather than a permanent stall.

Parameters:
ADDR_WIDTH, 32, physical address width
DATA_WIDTH, 32, data bus width; column strobe width is DATA_WIDTH/8
TIMEOUT_CYCLES, 256, BUSY cycles without ack before the transaction faults
MAX_MEM_GRANTS, 4, consecutive MEM grants before a waiting IF request must win (fairness feature only)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request, held until completion
if_addr  in  ADDR_WIDTH  fetch physical address
if_rdata  out  DATA_WIDTH  fetched word, valid in IF completion cycle
if_stall  out  1  fetch not complete this cycle
if_bus_fault  out  1  one-cycle pulse: fetch timed out
mem_req  in  1  data request, held until completion
mem_addr  in  ADDR_WIDTH  data physical address
mem_wdata  in  DATA_WIDTH  store data
mem_read_write  in  1  1=write, 0=read
mem_column_strobe  in  DATA_WIDTH/8  byte enables
mem_rdata  out  DATA_WIDTH  load data, valid in MEM completion cycle
mem_stall  out  1  data access not complete this cycle
mem_bus_fault  out  1  one-cycle pulse: data access timed out
phys_req  out  1  physical bus request
phys_addr  out  ADDR_WIDTH  physical address
phys_wdata  out  DATA_WIDTH  physical write data
phys_read_write  out  1  1=write
phys_column_strobe  out  DATA_WIDTH/8  byte enables; all ones for fetch
phys_rdata  in  DATA_WIDTH  read data, valid with phys_ack
phys_ack  in  1  slave completion, one cycle

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- States:
  - IDLE: no transaction.
  - BUSY: transaction owned by owner.
  - DRAIN: owner dropped its request; wait for ack or timeout, discard result.
- Reset values: state=IDLE, owner=MEM, phys_req=0, phys_addr/phys_wdata/phys_column_strobe=0, phys_read_write=0, timeout counter=0, grant counter=0.
- Reset mid-transaction returns to IDLE next edge with phys_req=0. A later ack is ignored.
- IDLE arbitration:
  - MEM has priority over IF; the older instruction wins.
  - Winner's address, data, rw and strobe are registered onto phys_* and phys_req=1.
  - Next state is BUSY, counter=0.
  - Minimum latency: request in cycle N, phys_req high in N+1, completion no earlier than N+1.
- phys_* outputs are registered and held stable for the whole of BUSY/DRAIN.
- BUSY with phys_ack=1:
  - Completion cycle for owner: owner's stall=0; owner's rdata=phys_rdata (combinational pass-through).
  - phys_req drops next edge; state goes to IDLE.
  - A request held by the other port is arbitrated in the IDLE cycle that follows. No back-to-back grant in the ack cycle.
- BUSY without ack: counter increments. At counter==TIMEOUT_CYCLES-1:
  - Completion with owner's bus_fault=1 and stall=0 for that cycle.
  - phys_req drops; state goes to IDLE.
- Stall rule: x_stall = x_req & ~(completion for x this cycle). With no request, stall=0.
- Owner deasserts req while BUSY (pipeline flush): go to DRAIN. No stall or fault is reported to either port for the drained transaction.
- DRAIN exits to IDLE on ack or timeout.
- rdata outputs are 0 outside their own completion cycle.
- Fault pulses are exactly one cycle. Fault and ack in the same cycle: ack wins, no fault.
- Simultaneous if_req and mem_req in IDLE: MEM granted; IF stalls through MEM's transaction and wins the following IDLE cycle.

Optional Feature:
ARB_FAIRNESS_EN
- Defined: a grant counter tracks consecutive MEM grants made while if_req was pending.
  - When the counter reaches MAX_MEM_GRANTS, the next IDLE arbitration with both requesting grants IF.
  - Counter clears on any IF grant, or on any IDLE cycle with if_req=0.
- Undefined: strict MEM priority; no counter logic is synthesized.

Decomposition:
- Shared core package holds:
  - ArbOwner enum (OWNER_IF, OWNER_MEM).
  - ArbState enum (ARB_IDLE, ARB_BUSY, ARB_DRAIN).
  - Bus request struct (addr, wdata, readWrite, columnStrobe).
- One sub-module: bus_timeout_counter (clear, enable, expired) with parameter TIMEOUT_CYCLES.

Test Plan:
1. Single IF read: if_req=1, if_addr=0x100, slave acks 3 cycles after phys_req with 0xDEADBEEF -> if_stall high 3 cycles, low in ack cycle with if_rdata=0xDEADBEEF; phys_column_strobe=4'hF.
2. Contention: if_req and mem_req (write 0x55AA55AA to 0x2000, strobe 4'h3) same cycle, 1-cycle acks -> MEM on bus first with phys_read_write=1; IF phys_req one idle cycle after MEM completes.
3. Timeout: mem_req read 0x3000, TIMEOUT_CYCLES=8, no ack -> mem_bus_fault pulse in 8th BUSY cycle, mem_stall=0 that cycle, phys_req low next cycle.
4. Flush: mem_req dropped 1 cycle into BUSY, ack 2 cycles later -> state DRAIN, mem_stall/mem_bus_fault never asserted, a pending IF request is granted after ack.
5. Reset mid-BUSY: reset pulsed with phys_req=1 -> phys_req=0 next edge, late phys_ack ignored, both stalls follow requests only.
6. Fairness (ARB_FAIRNESS_EN, MAX_MEM_GRANTS=4): continuous mem_req and if_req -> 4 MEM grants then 1 IF grant, repeating. Without the macro, IF is never granted.
